// File: rtl/index_stream_monitor.sv
// index_stream_monitor: locks onto the 4-step step/index pattern, counts completed
// sequences and flags, counts and captures deviations seen while locked.
module index_stream_monitor #(
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       step_in,
    input  logic [3:0]       index_in,
    output logic             locked,
    output logic             err,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [7:0]       err_cnt,
    output logic [3:0]       err_step,
    output logic [3:0]       err_index
);
    typedef enum logic [1:0] {SEARCH = 2'd0, LOCK = 2'd1, TRACK = 2'd2} state_t;

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_good, w_good_nxt;
    logic [1:0] r_last;
    logic [3:0] w_exp_idx;
    logic       w_good, w_err_ev, w_cyc;

    // Only the low two bits of the previous step matter for the mod-4 continuity check.
    always_comb begin
        w_exp_idx = step_in == 4'd0 ? 4'd0 : step_in == 4'd1 ? 4'd5 : step_in == 4'd2 ? 4'd12 : 4'd7;
        w_good    = (step_in < 4'd4) && (index_in == w_exp_idx) &&
                    (r_state == SEARCH || step_in[1:0] == r_last + 2'd1);
        w_err_ev  = en && r_state == TRACK && !w_good;
        w_cyc     = en && r_state == TRACK && w_good && step_in == 4'd0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            SEARCH: if (w_good) begin
                w_good_nxt  = 4'd1;
                w_state_nxt = (LC == 4'd1) ? TRACK : LOCK;
            end
            LOCK: if (w_good) begin
                w_good_nxt = r_good + 4'd1;
                if (r_good + 4'd1 == LC) w_state_nxt = TRACK;
            end else begin
                w_good_nxt  = 4'd0;
                w_state_nxt = SEARCH;
            end
            TRACK: if (!w_good) begin
                w_good_nxt  = 4'd0;
                w_state_nxt = SEARCH;
            end
            default: begin
                w_good_nxt  = 4'd0;
                w_state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
            r_good  <= 4'd0;
            r_last  <= 2'd0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            r_last  <= step_in[1:0];
        end
    end

    // clr wins over a same-cycle error or sequence count; err_pulse is unaffected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            cycle_cnt <= '0;
            err_step  <= 4'd0;
            err_index <= 4'd0;
        end else begin
            err_pulse <= w_err_ev;
            if (clr) begin
                err       <= 1'b0;
                err_cnt   <= 8'd0;
                cycle_cnt <= '0;
                err_step  <= 4'd0;
                err_index <= 4'd0;
            end else begin
                if (w_err_ev) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    if (!err) begin
                        err_step  <= step_in;
                        err_index <= index_in;
                    end
                end
                if (w_cyc) cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    assign locked = (r_state == TRACK);
endmodule

// File: tb/tb_index_stream_monitor.sv
// tb_index_stream_monitor: table vectors, directed corner sequences and random
// stimulus checked against a run-length reference model.
module tb_index_stream_monitor;
    localparam int LC = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, en, clr;
    logic [3:0]    step_in, index_in;
    logic          locked, err, err_pulse;
    logic [CW-1:0] cycle_cnt;
    logic [7:0]    err_cnt;
    logic [3:0]    err_step, err_index;

    index_stream_monitor #(.LOCK_COUNT(LC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .step_in(step_in), .index_in(index_in),
        .locked(locked), .err(err), .err_pulse(err_pulse),
        .cycle_cnt(cycle_cnt), .err_cnt(err_cnt),
        .err_step(err_step), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: length of the current run of good samples; locked once it reaches LC.
    int m_run, m_last, m_err, m_pulse, m_ccnt, m_ecnt, m_estep, m_eidx;

    typedef struct {
        logic [3:0] s;
        logic [3:0] i;
        int         e_locked;
        int         e_ccnt;
    } vec_t;
    vec_t tbl[7];

    function automatic int exp_idx(int s);
        return s == 0 ? 0 : s == 1 ? 5 : s == 2 ? 12 : 7;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_last = 0; m_err = 0; m_pulse = 0;
        m_ccnt = 0; m_ecnt = 0; m_estep = 0; m_eidx = 0;
    endtask

    task automatic model_step();
        int s, ix;
        bit good, ev, cyc;
        s = int'(step_in);
        ix = int'(index_in);
        good = s < 4 && ix == exp_idx(s) && (m_run == 0 || s == (m_last + 1) % 4);
        ev = 0;
        cyc = 0;
        m_pulse = 0;
        if (en) begin
            ev = m_run >= LC && !good;
            cyc = m_run >= LC && good && s == 0;
            m_pulse = ev;
            m_run = good ? (m_run < 100 ? m_run + 1 : 100) : 0;
            m_last = s;
        end
        if (clr) begin
            m_err = 0; m_ecnt = 0; m_ccnt = 0; m_estep = 0; m_eidx = 0;
        end else begin
            if (ev) begin
                if (!m_err) begin
                    m_estep = s;
                    m_eidx = ix;
                end
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
            if (cyc) m_ccnt = (m_ccnt + 1) % (1 << CW);
        end
    endtask

    task automatic cyc(input bit e, input bit c, input int s, input int i);
        en = e;
        clr = c;
        step_in = 4'(s);
        index_in = 4'(i);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all(input string t);
        chk({t, ".locked"}, int'(locked), int'(m_run >= LC));
        chk({t, ".err"}, int'(err), m_err);
        chk({t, ".err_pulse"}, int'(err_pulse), m_pulse);
        chk({t, ".cycle_cnt"}, int'(cycle_cnt), m_ccnt);
        chk({t, ".err_cnt"}, int'(err_cnt), m_ecnt);
        chk({t, ".err_step"}, int'(err_step), m_estep);
        chk({t, ".err_index"}, int'(err_index), m_eidx);
    endtask

    task automatic good_cyc(input int s);
        cyc(1, 0, s, exp_idx(s));
    endtask

    initial begin
        int rs, r, s, i;
        bit e, c;
        tbl[0] = '{4'd2, 4'd1,  0, 0};
        tbl[1] = '{4'd3, 4'd7,  0, 0};
        tbl[2] = '{4'd0, 4'd0,  1, 0};
        tbl[3] = '{4'd1, 4'd5,  1, 0};
        tbl[4] = '{4'd2, 4'd12, 1, 0};
        tbl[5] = '{4'd3, 4'd7,  1, 0};
        tbl[6] = '{4'd0, 4'd0,  1, 1};

        rst = 1'b1; en = 1'b0; clr = 1'b0; step_in = 4'd0; index_in = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        for (int k = 0; k < 7; k++) begin
            cyc(1, 0, int'(tbl[k].s), int'(tbl[k].i));
            chk($sformatf("tbl%0d.locked", k), int'(locked), tbl[k].e_locked);
            chk($sformatf("tbl%0d.cycle_cnt", k), int'(cycle_cnt), tbl[k].e_ccnt);
            chk($sformatf("tbl%0d.err", k), int'(err), 0);
            chk($sformatf("tbl%0d.err_pulse", k), int'(err_pulse), 0);
            check_all($sformatf("tbl%0d", k));
        end

        cyc(1, 0, 2, 11);
        chk("inj.pulse", int'(err_pulse), 1);
        chk("inj.err_cnt", int'(err_cnt), 1);
        chk("inj.err_step", int'(err_step), 2);
        chk("inj.err_index", int'(err_index), 11);
        chk("inj.locked", int'(locked), 0);
        check_all("inj");
        good_cyc(3);
        chk("inj.pulse_gone", int'(err_pulse), 0);
        chk("relock1", int'(locked), 0);
        good_cyc(0);
        chk("relock2", int'(locked), 1);
        check_all("relock");

        cyc(0, 1, 0, 0);
        chk("clr_noen.err", int'(err), 0);
        chk("clr_noen.locked", int'(locked), 1);
        check_all("clr_noen");
        good_cyc(1);
        cyc(1, 0, 3, 7);
        chk("skip.err", int'(err), 1);
        chk("skip.err_step", int'(err_step), 3);
        chk("skip.err_index", int'(err_index), 7);
        check_all("skip");
        good_cyc(0);
        good_cyc(1);
        cyc(1, 0, 3, 0);
        chk("second.err_cnt", int'(err_cnt), 2);
        chk("second.err_step", int'(err_step), 3);
        chk("second.err_index", int'(err_index), 7);
        check_all("second");

        good_cyc(0);
        good_cyc(1);
        good_cyc(2);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 2, 12);
            chk("en_low.locked", int'(locked), 1);
            chk("en_low.pulse", int'(err_pulse), 0);
            check_all("en_low");
        end
        good_cyc(3);
        chk("resume.pulse", int'(err_pulse), 0);
        chk("resume.err_cnt", int'(err_cnt), 2);
        check_all("resume");

        cyc(1, 1, 2, 2);
        chk("clr_ev.err", int'(err), 0);
        chk("clr_ev.err_cnt", int'(err_cnt), 0);
        chk("clr_ev.pulse", int'(err_pulse), 1);
        chk("clr_ev.locked", int'(locked), 0);
        check_all("clr_ev");

        for (int k = 0; k < 260; k++) begin
            good_cyc(0);
            good_cyc(1);
            cyc(1, 0, 3, 7);
        end
        chk("sat.err_cnt", int'(err_cnt), 255);
        check_all("sat");

        good_cyc(0);
        good_cyc(1);
        chk("pre_rst.locked", int'(locked), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.locked", int'(locked), 0);
        chk("arst.err_cnt", int'(err_cnt), 0);
        check_all("arst");
        @(negedge clk);
        rst = 1'b0;

        rs = 0;
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            s = rs;
            i = exp_idx(s);
            if (r >= 80 && r < 90) i = $urandom_range(0, 15);
            if (r >= 90) begin
                s = $urandom_range(0, 15);
                i = $urandom_range(0, 15);
            end
            e = $urandom_range(0, 9) != 0;
            c = $urandom_range(0, 49) == 0;
            if (e) rs = (s + 1) % 4;
            cyc(e, c, s, i);
            check_all($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/index_stream_monitor.md
# index_stream_monitor

Sequence checker placed directly downstream of the 4-step status counter. It samples the counter's step number and index value every enabled cycle. It locks onto the repeating step/index pattern, counts completed sequences, and flags, counts and captures any deviation. Its outputs feed the debug/LED status logic.

## Interface

- LOCK_COUNT, 2: consecutive good samples required to declare lock (legal range 1..15)
- CNT_W, 16: width of the completed-sequence counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample enable; when low, all state holds
- clr  in  1  synchronous clear of counters and error capture
- step_in  in  4  upstream step number
- index_in  in  4  upstream index value
- locked  out  1  high while in TRACK
- err  out  1  sticky error flag
- err_pulse  out  1  one-cycle pulse per detected error
- cycle_cnt  out  CNT_W  completed sequences while locked, wraps
- err_cnt  out  8  error count, saturates at 255
- err_step  out  4  step_in of the first error since reset/clr
- err_index  out  4  index_in of the first error since reset/clr

## Operation

- Expected pairs: step 0→index 0, step 1→5, step 2→12, step 3→7. Steps 4..15 are illegal.
- A sample is "good" when:
  - step_in is legal,
  - index_in matches the expected value for that step, and
  - for every state except SEARCH, step_in == (last sampled step + 1) mod 4.
- The last sampled step register updates on every enabled sample, good or bad.
- FSM, evaluated only when en=1:
  - SEARCH:
    - good sample → LOCK with good count = 1.
    - If LOCK_COUNT = 1, a good sample goes directly to TRACK instead.
    - Bad sample → stay in SEARCH.
  - LOCK:
    - good sample → increment good count; when it reaches LOCK_COUNT → TRACK.
    - Bad sample → SEARCH, count cleared, no error reported.
  - TRACK:
    - good sample → stay in TRACK.
    - Bad sample → error event, then SEARCH.
- locked = (state == TRACK).
- Error event (TRACK + bad sample only):
  - err_pulse=1 for exactly one cycle.
  - err set (sticky).
  - err_cnt increments, saturating at 255.
  - If err was 0 before this event, err_step/err_index capture step_in/index_in.
- cycle_cnt increments by 1, wrapping at 2^CNT_W, when the state is TRACK before the edge and a good sample with step_in=0 arrives. A good sample implies the previous step was 3.
- clr=1:
  - Clears err, err_cnt, cycle_cnt, err_step and err_index.
  - Has priority over a same-cycle error event or cycle increment; neither counter nor capture is updated.
  - err_pulse and FSM transitions still occur normally.
  - clr works regardless of en.
- en=0: no sample, no transitions, no counting. err_pulse is 0.

## Timing

- Reset values: state SEARCH, good count 0, last step 0, locked 0, err 0, err_pulse 0, cycle_cnt 0, err_cnt 0, err_step 0, err_index 0.
- rst asserted mid-operation forces all of the above immediately, without waiting for clk.
- All outputs are registered; latency is 1 cycle.
  - A sample taken at edge N is reflected on locked/err/err_pulse/counters after edge N.
- Inputs are sampled directly. Upstream is synchronous on the same clk, so no synchronizer is used.
- Throughput: one sample per enabled cycle, no backpressure.

## Test plan

- Upstream post-reset stream (2,1),(3,7),(0,0),(1,5),(2,12),(3,7),(0,0) with en=1, LOCK_COUNT=2:
  - Sample 1 is rejected.
  - locked=1 after sample 3.
  - cycle_cnt=1 after sample 7.
  - err stays 0 throughout.
- While locked, inject (2,11):
  - err_pulse=1 for one cycle.
  - err=1, err_cnt=1, err_step=2, err_index=11.
  - locked=0.
  - Relock after 2 good samples.
- While locked, inject a step skip (1,5)→(3,7):
  - Error is flagged.
  - A second error later leaves err_step=3/err_index=7 unchanged and sets err_cnt=2.
- Toggle en low for 5 cycles mid-sequence while the upstream is frozen:
  - No state change and no pulses.
  - Resuming with the next step gives no error.
- clr coincident with an error event: err=0, err_cnt=0, err_pulse=1, locked=0. Also force 256 errors and check err_cnt saturates at 255.
- Assert rst asynchronously between clock edges while locked: all outputs go to reset values immediately.
